// File: rtl/uart_cmd_decoder_pkg.sv
// uart_cmd_decoder_pkg: host command opcodes shared by the decoder and its users
package uart_cmd_decoder_pkg;
   typedef enum logic [7:0] {
      CMD_FREQ   = 8'h01,
      CMD_PERIOD = 8'h02,
      CMD_DATA   = 8'h03,
      CMD_CTRL   = 8'h04,
      CMD_REPEAT = 8'h05,
      CMD_GLOBAL = 8'h06
   } cmd_op_t;
endpackage

// File: rtl/uart_cmd_decoder_cmd_timeout_cnt.sv
// uart_cmd_decoder_cmd_timeout_cnt: inter-byte stall counter; expire_o pulses on the TIMEOUT_CYCLES-th idle enabled cycle
// clk_i/rst_i clock and sync reset; clr_i restarts the count; en_i counts; expire_o expiry pulse (never when TIMEOUT_CYCLES=0)
module uart_cmd_decoder_cmd_timeout_cnt #(
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);
   localparam int W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [W-1:0] cnt;
   always_ff @(posedge clk_i)
      cnt <= (rst_i || clr_i || !en_i) ? '0 : cnt + W'(1);
   // a clear in the expiry cycle suppresses it, so a late byte still counts
   assign expire_o = en_i && !clr_i && ({1'b0, cnt} + (W+1)'(1) == (W+1)'(TIMEOUT_CYCLES));
endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: reassembles UART command frames into one decoded command (or error) per frame
// clk_i/rst_i clock and sync reset; data_i/rx_done_tick_i received byte and strobe;
// cmd_valid_o/cmd_err_o completion pulses; cmd_op_o, ch_o, amount_o, pattern_o, arg0_o, arg1_o decoded fields
module uart_cmd_decoder
   import uart_cmd_decoder_pkg::*;
#(
   parameter int DATA_BIT       = 32,
   parameter int OUTPUT_NUM     = 16,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [7:0]          data_i,
   input  logic                rx_done_tick_i,
   output logic                cmd_valid_o,
   output logic                cmd_err_o,
   output logic [7:0]          cmd_op_o,
   output logic [7:0]          ch_o,
   output logic [7:0]          amount_o,
   output logic [DATA_BIT-1:0] pattern_o,
   output logic [7:0]          arg0_o,
   output logic [7:0]          arg1_o
);
   localparam int NB = DATA_BIT / 8;
   typedef enum logic [2:0] {S_IDLE, S_CHAN, S_AMOUNT, S_PAYLOAD, S_ARG0, S_ARG1} state_t;
   state_t state;
   logic [7:0] op, ch, amt, arg0, arg1, k;
   logic [DATA_BIT-1:0] pattern, pat_nx;
   logic bad, fin, expire;
   uart_cmd_decoder_cmd_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clr_i    (rx_done_tick_i),
      .en_i     (state != S_IDLE),
      .expire_o (expire)
   );
   // payload bytes beyond the pattern width are counted but dropped
   always_comb begin
      pat_nx = pattern;
      for (int i = 0; i < NB; i++)
         if (state == S_PAYLOAD && 32'(k) == i) pat_nx[i*8 +: 8] = data_i;
      fin = rx_done_tick_i && ((state == S_PAYLOAD && k == amt) ||
                               (state == S_ARG0 && op != CMD_PERIOD) || state == S_ARG1);
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         op          <= '0;
         ch          <= '0;
         amt         <= '0;
         arg0        <= '0;
         arg1        <= '0;
         k           <= '0;
         pattern     <= '0;
         bad         <= 1'b0;
         cmd_valid_o <= 1'b0;
         cmd_err_o   <= 1'b0;
         cmd_op_o    <= '0;
         ch_o        <= '0;
         amount_o    <= '0;
         pattern_o   <= '0;
         arg0_o      <= '0;
         arg1_o      <= '0;
      end else begin
         cmd_valid_o <= fin && !bad;
         cmd_err_o   <= fin && bad;
         if (rx_done_tick_i) begin
            case (state)
               S_IDLE: begin
                  op   <= data_i;
                  ch   <= '0;
                  amt  <= '0;
                  arg0 <= '0;
                  arg1 <= '0;
                  bad  <= 1'b0;
                  case (data_i)
                     CMD_DATA, CMD_CTRL, CMD_REPEAT: state <= S_CHAN;
                     CMD_FREQ:                       state <= S_AMOUNT;
                     CMD_PERIOD, CMD_GLOBAL:         state <= S_ARG0;
                     default: begin
                        cmd_err_o <= 1'b1;
                        cmd_op_o  <= data_i;
                     end
                  endcase
               end
               S_CHAN: begin
                  ch    <= data_i;
                  bad   <= bad || 32'(data_i) >= OUTPUT_NUM;
                  state <= op == CMD_DATA ? S_AMOUNT : S_ARG0;
               end
               S_AMOUNT: begin
                  amt     <= data_i;
                  bad     <= bad || 32'(data_i) >= NB;
                  pattern <= '0;
                  k       <= '0;
                  state   <= S_PAYLOAD;
               end
               S_PAYLOAD: begin
                  pattern <= pat_nx;
                  k       <= k + 8'd1;
               end
               S_ARG0: begin
                  arg0  <= data_i;
                  state <= S_ARG1;
               end
               S_ARG1:  arg1 <= data_i;
               default: state <= S_IDLE;
            endcase
         end else if (expire) begin
            state     <= S_IDLE;
            cmd_err_o <= 1'b1;
            cmd_op_o  <= op;
         end
         if (fin) begin
            state     <= S_IDLE;
            cmd_op_o  <= op;
            ch_o      <= ch;
            amount_o  <= amt;
            pattern_o <= pat_nx;
            arg0_o    <= state == S_ARG0 ? data_i : arg0;
            arg1_o    <= state == S_ARG1 ? data_i : arg1;
         end
      end
   end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: scoreboard bench for uart_cmd_decoder with directed frames
module tb_uart_cmd_decoder;
   logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
   logic [7:0] data = 8'h00;
   logic cmd_valid, cmd_err;
   logic [7:0] cmd_op, ch, amount, arg0, arg1;
   logic [31:0] pattern;
   typedef struct {
      logic err;
      logic [7:0] op, ch, amt, a0, a1;
      logic [31:0] pat;
   } exp_t;
   exp_t q[$];
   int n_vec = 0, n_err = 0;
   uart_cmd_decoder #(.DATA_BIT(32), .OUTPUT_NUM(16), .TIMEOUT_CYCLES(100)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .data_i         (data),
      .rx_done_tick_i (tick),
      .cmd_valid_o    (cmd_valid),
      .cmd_err_o      (cmd_err),
      .cmd_op_o       (cmd_op),
      .ch_o           (ch),
      .amount_o       (amount),
      .pattern_o      (pattern),
      .arg0_o         (arg0),
      .arg1_o         (arg1)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask
   task automatic chk_zero(input string nm);
      chk({nm, "_valid"}, 32'(cmd_valid), 0);
      chk({nm, "_err"}, 32'(cmd_err), 0);
      chk({nm, "_op"}, 32'(cmd_op), 0);
      chk({nm, "_ch"}, 32'(ch), 0);
      chk({nm, "_amt"}, 32'(amount), 0);
      chk({nm, "_pat"}, pattern, 0);
      chk({nm, "_arg0"}, 32'(arg0), 0);
      chk({nm, "_arg1"}, 32'(arg1), 0);
   endtask
   task automatic expect_cmd(input logic err, input logic [7:0] op, input logic [7:0] c,
                             input logic [7:0] amt, input logic [31:0] pat,
                             input logic [7:0] a0, input logic [7:0] a1);
      q.push_back('{err, op, c, amt, a0, a1, pat});
   endtask
   task automatic tx(input logic [7:0] b);
      @(negedge clk);
      data = b;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
   endtask
   always @(negedge clk) begin
      exp_t e;
      if (cmd_valid || cmd_err) begin
         chk("both_pulses", 32'(cmd_valid && cmd_err), 0);
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_pulse: got valid=%0b err=%0b op=%h expected no pulse", cmd_valid, cmd_err, cmd_op);
         end else begin
            e = q.pop_front();
            chk("kind_err", 32'(cmd_err), 32'(e.err));
            chk("op", 32'(cmd_op), 32'(e.op));
            if (!e.err) begin
               chk("arg1", 32'(arg1), 32'(e.a1));
               if (e.op inside {8'h03, 8'h04, 8'h05}) chk("ch", 32'(ch), 32'(e.ch));
               if (e.op inside {8'h01, 8'h03}) begin
                  chk("amt", 32'(amount), 32'(e.amt));
                  chk("pattern", pattern, e.pat);
               end
               if (e.op inside {8'h02, 8'h04, 8'h05, 8'h06}) chk("arg0", 32'(arg0), 32'(e.a0));
            end
         end
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1);
   end
   initial begin
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      expect_cmd(0, 8'h03, 8'h00, 8'h03, 32'h5500_5500, 8'h00, 8'h00);
      tx(8'h03); tx(8'h00); tx(8'h03); tx(8'h00); tx(8'h55); tx(8'h00); tx(8'h55);
      expect_cmd(0, 8'h04, 8'h00, 8'h00, 32'h0, 8'h01, 8'h00);
      tx(8'h04); tx(8'h00); tx(8'h01);
      expect_cmd(0, 8'h06, 8'h00, 8'h00, 32'h0, 8'h01, 8'h00);
      tx(8'h06); tx(8'h01);
      expect_cmd(0, 8'h02, 8'h00, 8'h00, 32'h0, 8'h14, 8'h05);
      tx(8'h02); tx(8'h14); tx(8'h05);
      expect_cmd(0, 8'h04, 8'h0F, 8'h00, 32'h0, 8'h07, 8'h00);
      tx(8'h04); tx(8'h0F); tx(8'h07);
      expect_cmd(0, 8'h05, 8'h0F, 8'h00, 32'h0, 8'h03, 8'h00);
      tx(8'h05); tx(8'h0F); tx(8'h03);
      expect_cmd(1, 8'h7F, 8'h00, 8'h00, 32'h0, 8'h00, 8'h00);
      tx(8'h7F);
      expect_cmd(1, 8'h05, 8'h00, 8'h00, 32'h0, 8'h00, 8'h00);
      tx(8'h05); tx(8'h10); tx(8'h03);
      expect_cmd(1, 8'h03, 8'h00, 8'h00, 32'h0, 8'h00, 8'h00);
      tx(8'h03); tx(8'h00); tx(8'h04); tx(8'h11); tx(8'h22); tx(8'h33); tx(8'h44); tx(8'h99);
      expect_cmd(0, 8'h06, 8'h00, 8'h00, 32'h0, 8'h00, 8'h00);
      tx(8'h06); tx(8'h00);
      expect_cmd(0, 8'h03, 8'h01, 8'h03, 32'h4433_2211, 8'h00, 8'h00);
      tx(8'h03); tx(8'h01); tx(8'h03); tx(8'h11); tx(8'h22); tx(8'h33); tx(8'h44);
      expect_cmd(0, 8'h01, 8'h00, 8'h01, 32'h0000_BBAA, 8'h00, 8'h00);
      tx(8'h01); tx(8'h01); tx(8'hAA); tx(8'hBB);
      expect_cmd(0, 8'h03, 8'h02, 8'h00, 32'h0000_005A, 8'h00, 8'h00);
      tx(8'h03); tx(8'h02); tx(8'h00); tx(8'h5A);
      expect_cmd(1, 8'h01, 8'h00, 8'h00, 32'h0, 8'h00, 8'h00);
      tx(8'h01); tx(8'hFF);
      for (int i = 0; i < 256; i++) tx(8'(i));
      expect_cmd(0, 8'h06, 8'h00, 8'h00, 32'h0, 8'h01, 8'h00);
      tx(8'h06); tx(8'h01);
      expect_cmd(1, 8'h03, 8'h00, 8'h00, 32'h0, 8'h00, 8'h00);
      tx(8'h03); tx(8'h00);
      repeat (150) @(negedge clk);
      expect_cmd(0, 8'h06, 8'h00, 8'h00, 32'h0, 8'h00, 8'h00);
      tx(8'h06); tx(8'h00);
      tx(8'h02); tx(8'h14);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_zero("midframe_rst");
      expect_cmd(0, 8'h02, 8'h00, 8'h00, 32'h0, 8'h14, 8'h05);
      tx(8'h02); tx(8'h14); tx(8'h05);
      repeat (20) @(negedge clk);
      chk("pending", 32'(q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
